parking_exit_gate: RTL and testbench
====================================

PARKING_EXIT_GATE -- requirements
Module: parking_exit_gate

Interface
REQ-001 Parameter CAPACITY, default 8: number of parking slots; occupancy saturates here.
REQ-002 Parameter TOKEN_TIMEOUT, default 16: cycles allowed in WAIT_TOKEN before abandoning.
REQ-003 Parameter OPEN_TIMEOUT, default 32: cycles the gate stays open without a car passing.
REQ-004 Parameter MAX_TRIES, default 3: wrong tokens allowed before LOCKOUT.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 car_entered  in  1  one-cycle pulse from the entrance controller when a car enters the lot.
REQ-009 sensor_exit  in  1  car present at the exit booth.
REQ-010 sensor_gate  in  1  car physically under the exit gate.
REQ-011 token_valid  in  1  one-cycle strobe qualifying pass_1/pass_2.
REQ-012 pass_1, pass_2  in  2 each  exit token digits.
REQ-013 gate_open  out  1  gate actuator.
REQ-014 green_led, red_led  out  1 each  booth lamps.
REQ-015 alarm  out  1  lockout indicator.
REQ-016 occupancy  out  4  cars currently in the lot.
REQ-017 lot_full  out  1  high when occupancy == CAPACITY.
REQ-018 hex_1, hex_2  out  7 each  active-low 7-segment booth display.

Function
REQ-019 FSM states: IDLE, WAIT_TOKEN, OPEN, LOCKOUT; all outputs decode from the state register, so any transition taken at edge N is visible from cycle N+1.
REQ-020 IDLE -> WAIT_TOKEN when sensor_exit=1 and occupancy>0; with occupancy 0, sensor_exit is ignored; try counter and timer clear on entry.
REQ-021 WAIT_TOKEN: token_valid with pass_1=2'b10, pass_2=2'b01 -> OPEN.
REQ-022 WAIT_TOKEN: token_valid with any other code increments tries; the MAX_TRIES-th wrong token -> LOCKOUT.
REQ-023 WAIT_TOKEN -> IDLE when sensor_exit drops or the timer reaches TOKEN_TIMEOUT-1 with no token; a valid token in that same cycle wins.
REQ-024 OPEN: gate_open=1; a falling edge of sensor_gate (1 then 0) decrements occupancy and returns to IDLE.
REQ-025 OPEN -> IDLE after OPEN_TIMEOUT cycles if sensor_gate never rose; occupancy unchanged. If sensor_gate is high at timeout, remain OPEN until it falls.
REQ-026 LOCKOUT: alarm=1, red_led toggles every cycle; exits to IDLE only on token_valid with pass_1=2'b11, pass_2=2'b11 (service code) or reset.
REQ-027 Occupancy: car_entered increments, saturating at CAPACITY; an exit decrements, saturating at 0; both in the same cycle leave it unchanged.
REQ-028 Lamps: IDLE/WAIT_TOKEN red=1, green=0; OPEN green=1, red=0; LOCKOUT green=0.
REQ-029 Display: IDLE 7'b1111111/7'b1111111; WAIT_TOKEN 7'b0000110/7'b0101011; OPEN 7'b0000010/7'b1000000; LOCKOUT 7'b0001000/7'b1000111.
REQ-030 token_valid outside WAIT_TOKEN/LOCKOUT is ignored.

Reset
REQ-031 On reset: state IDLE, occupancy 0, tries 0, timers 0, gate_open 0, green_led 0, red_led 1, alarm 0, lot_full 0, hex both 7'b1111111.
REQ-032 Reset mid-operation (any state) takes effect at the next edge and overrides all other inputs that cycle.

Structure
REQ-033 Shared package parking_pkg holds the state enum, exit/service token codes, and the hex segment constants.
REQ-034 Occupancy counter is a sub-module parking_occupancy (inc, dec, CAPACITY, saturating count, full).

Verification
REQ-035 Reset, 3 car_entered pulses, sensor_exit=1, token 10/01 -> gate_open=1 one cycle later; sensor_gate 1 then 0 -> occupancy 3->2, IDLE.
REQ-036 Occupancy 2, three wrong tokens 01/01 -> LOCKOUT, alarm=1, red_led toggling; token 11/11 -> IDLE, alarm=0.
REQ-037 sensor_exit held, no token for 16 cycles -> IDLE, hex blank, occupancy unchanged.
REQ-038 10 car_entered pulses with CAPACITY=8 -> occupancy 8, lot_full=1; car_entered and exit decrement in the same cycle -> occupancy stays 8.
REQ-039 Occupancy 0, sensor_exit=1 -> stays IDLE; reset asserted while OPEN -> IDLE, gate_open=0, occupancy 0 next cycle.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared definitions for the parking exit gate: FSM states, token codes and
// active-low 7-segment patterns shown on the booth display.
package parking_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_TOKEN,
    ST_OPEN,
    ST_LOCKOUT
  } gate_state_t;

  localparam logic [1:0] EXIT_P1 = 2'b10;
  localparam logic [1:0] EXIT_P2 = 2'b01;
  localparam logic [1:0] SVC_P1  = 2'b11;
  localparam logic [1:0] SVC_P2  = 2'b11;

  localparam logic [6:0] HEX_BLANK = 7'b1111111;
  localparam logic [6:0] HEX_WAIT1 = 7'b0000110;
  localparam logic [6:0] HEX_WAIT2 = 7'b0101011;
  localparam logic [6:0] HEX_OPEN1 = 7'b0000010;
  localparam logic [6:0] HEX_OPEN2 = 7'b1000000;
  localparam logic [6:0] HEX_LOCK1 = 7'b0001000;
  localparam logic [6:0] HEX_LOCK2 = 7'b1000111;

  function automatic logic [6:0] hex1_of(input gate_state_t s);
    case (s)
      ST_WAIT_TOKEN: hex1_of = HEX_WAIT1;
      ST_OPEN:       hex1_of = HEX_OPEN1;
      ST_LOCKOUT:    hex1_of = HEX_LOCK1;
      default:       hex1_of = HEX_BLANK;
    endcase
  endfunction

  function automatic logic [6:0] hex2_of(input gate_state_t s);
    case (s)
      ST_WAIT_TOKEN: hex2_of = HEX_WAIT2;
      ST_OPEN:       hex2_of = HEX_OPEN2;
      ST_LOCKOUT:    hex2_of = HEX_LOCK2;
      default:       hex2_of = HEX_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/parking_occupancy.sv
// Saturating lot occupancy counter; simultaneous entry and exit cancel out.
module parking_occupancy #(
  parameter int unsigned CAPACITY = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] count,
  output logic       full
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      case ({inc, dec})
        2'b10:   if (count < 4'(CAPACITY)) count <= count + 4'd1;
        2'b01:   if (count != '0) count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

  assign full = (count == 4'(CAPACITY));

endmodule

// File: rtl/parking_exit_gate.sv
// Exit booth controller: validates exit tokens, drives the gate, lamps and
// display, and tracks lot occupancy through parking_occupancy.
module parking_exit_gate
  import parking_pkg::*;
#(
  parameter int unsigned CAPACITY      = 8,
  parameter int unsigned TOKEN_TIMEOUT = 16,
  parameter int unsigned OPEN_TIMEOUT  = 32,
  parameter int unsigned MAX_TRIES     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       car_entered,
  input  logic       sensor_exit,
  input  logic       sensor_gate,
  input  logic       token_valid,
  input  logic [1:0] pass_1,
  input  logic [1:0] pass_2,
  output logic       gate_open,
  output logic       green_led,
  output logic       red_led,
  output logic       alarm,
  output logic [3:0] occupancy,
  output logic       lot_full,
  output logic [6:0] hex_1,
  output logic [6:0] hex_2
);

  localparam int unsigned TMAX = (TOKEN_TIMEOUT > OPEN_TIMEOUT) ? TOKEN_TIMEOUT : OPEN_TIMEOUT;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam int unsigned RW   = $clog2(MAX_TRIES + 1);

  gate_state_t   state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [RW-1:0] tries, tries_n;
  logic          gate_seen;
  logic          exit_evt;
  logic          tok_exit, tok_svc, gate_fall;

  assign tok_exit  = token_valid && (pass_1 == EXIT_P1) && (pass_2 == EXIT_P2);
  assign tok_svc   = token_valid && (pass_1 == SVC_P1) && (pass_2 == SVC_P2);
  assign gate_fall = gate_seen && !sensor_gate;

  always_comb begin
    state_n  = state;
    timer_n  = timer;
    tries_n  = tries;
    exit_evt = 1'b0;
    case (state)
      ST_IDLE: begin
        timer_n = '0;
        tries_n = '0;
        if (sensor_exit && (occupancy != '0)) state_n = ST_WAIT_TOKEN;
      end
      ST_WAIT_TOKEN: begin
        // A token in the timeout cycle takes priority over abandoning.
        if (token_valid) begin
          if (tok_exit) begin
            state_n = ST_OPEN;
            timer_n = '0;
          end else begin
            tries_n = tries + 1'b1;
            if (tries == RW'(MAX_TRIES - 1)) state_n = ST_LOCKOUT;
            else if (timer != '1)            timer_n = timer + 1'b1;
          end
        end else if (!sensor_exit || (timer >= TW'(TOKEN_TIMEOUT - 1))) begin
          state_n = ST_IDLE;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      ST_OPEN: begin
        if (gate_fall) begin
          exit_evt = 1'b1;
          state_n  = ST_IDLE;
        end else if (timer >= TW'(OPEN_TIMEOUT - 1)) begin
          // A car still under the gate holds it open until it clears.
          if (!sensor_gate) state_n = ST_IDLE;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      ST_LOCKOUT: begin
        if (tok_svc) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      timer     <= '0;
      tries     <= '0;
      gate_seen <= 1'b0;
      gate_open <= 1'b0;
      green_led <= 1'b0;
      red_led   <= 1'b1;
      alarm     <= 1'b0;
      hex_1     <= HEX_BLANK;
      hex_2     <= HEX_BLANK;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      tries     <= tries_n;
      gate_seen <= (state == ST_OPEN && state_n == ST_OPEN) ? sensor_gate : 1'b0;
      gate_open <= (state_n == ST_OPEN);
      green_led <= (state_n == ST_OPEN);
      alarm     <= (state_n == ST_LOCKOUT);
      hex_1     <= hex1_of(state_n);
      hex_2     <= hex2_of(state_n);
      case (state_n)
        ST_OPEN:    red_led <= 1'b0;
        ST_LOCKOUT: red_led <= (state == ST_LOCKOUT) ? ~red_led : 1'b0;
        default:    red_led <= 1'b1;
      endcase
    end
  end

  parking_occupancy #(.CAPACITY(CAPACITY)) u_occupancy (
    .clk   (clk),
    .reset (reset),
    .inc   (car_entered),
    .dec   (exit_evt),
    .count (occupancy),
    .full  (lot_full)
  );

endmodule

// File: tb/tb_parking_exit_gate.sv
// Directed bench for parking_exit_gate with hand-computed expectations.
module tb_parking_exit_gate;

  logic       clk = 1'b0;
  logic       reset, car_entered, sensor_exit, sensor_gate, token_valid;
  logic [1:0] pass_1, pass_2;
  logic       gate_open, green_led, red_led, alarm, lot_full;
  logic [3:0] occupancy;
  logic [6:0] hex_1, hex_2;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  parking_exit_gate #(
    .CAPACITY(8), .TOKEN_TIMEOUT(16), .OPEN_TIMEOUT(32), .MAX_TRIES(3)
  ) dut (
    .clk(clk), .reset(reset), .car_entered(car_entered),
    .sensor_exit(sensor_exit), .sensor_gate(sensor_gate),
    .token_valid(token_valid), .pass_1(pass_1), .pass_2(pass_2),
    .gate_open(gate_open), .green_led(green_led), .red_led(red_led),
    .alarm(alarm), .occupancy(occupancy), .lot_full(lot_full),
    .hex_1(hex_1), .hex_2(hex_2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance n rising edges, leaving time 1ns past the last edge.
  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic token(input logic [1:0] p1, input logic [1:0] p2);
    token_valid = 1'b1;
    pass_1 = p1;
    pass_2 = p2;
    tick(1);
    token_valid = 1'b0;
    pass_1 = 2'b00;
    pass_2 = 2'b00;
  endtask

  initial begin
    reset = 1'b1; car_entered = 1'b0; sensor_exit = 1'b0; sensor_gate = 1'b0;
    token_valid = 1'b0; pass_1 = 2'b00; pass_2 = 2'b00;
    tick(2);
    reset = 1'b0;
    check("rst_gate", gate_open, 0);
    check("rst_green", green_led, 0);
    check("rst_red", red_led, 1);
    check("rst_alarm", alarm, 0);
    check("rst_occ", occupancy, 0);
    check("rst_full", lot_full, 0);
    check("rst_hex1", hex_1, 7'h7F);
    check("rst_hex2", hex_2, 7'h7F);

    // Empty lot ignores the exit sensor.
    sensor_exit = 1'b1;
    tick(3);
    check("empty_idle_hex1", hex_1, 7'h7F);
    check("empty_idle_red", red_led, 1);
    sensor_exit = 1'b0;

    // Three cars in, one leaves through the gate.
    car_entered = 1'b1; tick(3); car_entered = 1'b0;
    check("occ3", occupancy, 3);
    sensor_exit = 1'b1; tick(1);
    check("wait_hex1", hex_1, 7'b0000110);
    check("wait_hex2", hex_2, 7'b0101011);
    check("wait_red", red_led, 1);
    token(2'b10, 2'b01);
    sensor_exit = 1'b0;
    check("open_gate", gate_open, 1);
    check("open_green", green_led, 1);
    check("open_red", red_led, 0);
    check("open_hex1", hex_1, 7'b0000010);
    check("open_hex2", hex_2, 7'b1000000);
    sensor_gate = 1'b1; tick(1);
    check("open_gate_hi", gate_open, 1);
    sensor_gate = 1'b0; tick(1);
    check("exit_occ2", occupancy, 2);
    check("exit_gate0", gate_open, 0);
    check("exit_hex1", hex_1, 7'h7F);

    // Token in IDLE is ignored.
    token(2'b10, 2'b01);
    check("idle_tok_gate", gate_open, 0);
    check("idle_tok_hex1", hex_1, 7'h7F);

    // Three wrong tokens lead to lockout.
    sensor_exit = 1'b1; tick(1);
    token(2'b01, 2'b01);
    token(2'b01, 2'b01);
    check("two_wrong_alarm", alarm, 0);
    check("two_wrong_hex1", hex_1, 7'b0000110);
    token(2'b01, 2'b01);
    check("lock_alarm", alarm, 1);
    check("lock_green", green_led, 0);
    check("lock_red0", red_led, 0);
    check("lock_hex1", hex_1, 7'b0001000);
    check("lock_hex2", hex_2, 7'b1000111);
    tick(1);
    check("lock_red1", red_led, 1);
    tick(1);
    check("lock_red2", red_led, 0);
    token(2'b10, 2'b01);
    check("lock_exit_tok_alarm", alarm, 1);
    check("lock_exit_tok_gate", gate_open, 0);
    token(2'b11, 2'b11);
    sensor_exit = 1'b0;
    check("svc_alarm", alarm, 0);
    check("svc_red", red_led, 1);
    check("svc_hex1", hex_1, 7'h7F);
    check("svc_occ", occupancy, 2);

    // Token timeout: 16 cycles in WAIT_TOKEN then back to IDLE.
    sensor_exit = 1'b1; tick(1);
    tick(15);
    check("tmo_still_wait", hex_1, 7'b0000110);
    tick(1);
    sensor_exit = 1'b0;
    check("tmo_hex1", hex_1, 7'h7F);
    check("tmo_hex2", hex_2, 7'h7F);
    check("tmo_occ", occupancy, 2);

    // Dropping sensor_exit abandons the wait.
    sensor_exit = 1'b1; tick(1);
    sensor_exit = 1'b0; tick(1);
    check("drop_hex1", hex_1, 7'h7F);

    // Gate open timeout with no car passing.
    sensor_exit = 1'b1; tick(1);
    token(2'b10, 2'b01);
    sensor_exit = 1'b0;
    tick(31);
    check("otmo_still_open", gate_open, 1);
    tick(1);
    check("otmo_closed", gate_open, 0);
    check("otmo_occ", occupancy, 2);

    // Car under the gate at timeout keeps it open until it clears.
    sensor_exit = 1'b1; tick(1);
    token(2'b10, 2'b01);
    sensor_exit = 1'b0;
    sensor_gate = 1'b1;
    tick(40);
    check("hold_open", gate_open, 1);
    sensor_gate = 1'b0; tick(1);
    check("hold_closed", gate_open, 0);
    check("hold_occ", occupancy, 1);

    // Saturation at capacity, then simultaneous entry and exit.
    car_entered = 1'b1; tick(10); car_entered = 1'b0;
    check("sat_occ", occupancy, 8);
    check("sat_full", lot_full, 1);
    sensor_exit = 1'b1; tick(1);
    token(2'b10, 2'b01);
    sensor_exit = 1'b0;
    sensor_gate = 1'b1; tick(1);
    sensor_gate = 1'b0; car_entered = 1'b1; tick(1);
    car_entered = 1'b0;
    check("both_occ", occupancy, 8);
    check("both_full", lot_full, 1);
    check("both_idle", gate_open, 0);

    // Reset while OPEN.
    sensor_exit = 1'b1; tick(1);
    token(2'b10, 2'b01);
    check("pre_rst_open", gate_open, 1);
    reset = 1'b1; tick(1);
    reset = 1'b0; sensor_exit = 1'b0;
    check("mid_rst_gate", gate_open, 0);
    check("mid_rst_occ", occupancy, 0);
    check("mid_rst_red", red_led, 1);
    check("mid_rst_hex1", hex_1, 7'h7F);
    check("mid_rst_full", lot_full, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
